// File: rtl/input_conditioner_pkg.sv
// Shared defaults and sizing helpers for the input conditioner family.
// The UART and button-parser blocks import these defaults from here.
package input_conditioner_pkg;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_SAMPLE_PERIOD  = 1000;
    localparam int DEF_STABLE_SAMPLES = 4;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain async-reset flop pipeline: STAGES deep, WIDTH bits, nothing between stages.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s <= '0;
        end else begin
            r_s[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_s[i] <= r_s[i-1];
        end
    end

    assign o_q = r_s[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Per-channel synchronizer, optional tick-sampled debounce and registered edge pulses.
// All channels share one sample-tick prescaler.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_EN    = 1,
    parameter int SAMPLE_PERIOD  = DEF_SAMPLE_PERIOD,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (SAMPLE_PERIOD < 1) begin : g_bad_period
        $error("input_conditioner: SAMPLE_PERIOD must be >= 1");
    end
    if (STABLE_SAMPLES < 1) begin : g_bad_stable
        $error("input_conditioner: STABLE_SAMPLES must be >= 1");
    end

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    sync_chain #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_d    (async_in),
        .o_q    (w_sync)
    );

    if (DEBOUNCE_EN != 0) begin : g_deb
        localparam int PW = cnt_w(SAMPLE_PERIOD);
        localparam int CW = $clog2(STABLE_SAMPLES + 1);
        localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
        localparam logic [CW-1:0] C_LAST = CW'(STABLE_SAMPLES - 1);

        logic [PW-1:0] r_pcnt;
        logic [PW-1:0] w_pcnt_nxt;
        logic          r_tick;

        assign w_pcnt_nxt = (r_pcnt == P_LAST) ? '0 : r_pcnt + PW'(1);

        // Tick is registered off the next count so it reads 0 in reset even when SAMPLE_PERIOD=1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pcnt <= '0;
                r_tick <= 1'b0;
            end else begin
                r_pcnt <= w_pcnt_nxt;
                r_tick <= (w_pcnt_nxt == P_LAST);
            end
        end

        assign tick = r_tick;

        for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
            logic [CW-1:0] r_cnt;
            logic          w_diff;

            assign w_diff = (w_sync[ch] != r_level[ch]);
            assign w_level_nxt[ch] = (w_diff && r_tick && (r_cnt == C_LAST)) ? w_sync[ch] : r_level[ch];

            // Any sample agreeing with the current level throws away accumulated progress.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!w_diff) begin
                    r_cnt <= '0;
                end else if (r_tick) begin
                    r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
                end
            end
        end
    end else begin : g_bypass
        assign w_level_nxt = w_sync;
        assign tick        = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_rise  <= ~r_level & w_level_nxt;
            r_fall  <= r_level & ~w_level_nxt;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a debounce instance and a bypass instance share one input bus.
module tb_input_conditioner;

    localparam int W  = 4;
    localparam int SD = 2;   // debounce instance sync depth
    localparam int SB = 3;   // bypass instance sync depth
    localparam int SP = 4;
    localparam int SS = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] async_in = '0;
    logic [W-1:0] lv_db, ri_db, fa_db, lv_bp, ri_bp, fa_bp;
    logic         tk_db, tk_bp;

    input_conditioner #(.WIDTH(W), .SYNC_STAGES(SD), .DEBOUNCE_EN(1),
                        .SAMPLE_PERIOD(SP), .STABLE_SAMPLES(SS)) u_db (
        .clk(clk), .rst_n(rst_n), .async_in(async_in),
        .level(lv_db), .rise(ri_db), .fall(fa_db), .tick(tk_db));

    input_conditioner #(.WIDTH(W), .SYNC_STAGES(SB), .DEBOUNCE_EN(0),
                        .SAMPLE_PERIOD(SP), .STABLE_SAMPLES(SS)) u_bp (
        .clk(clk), .rst_n(rst_n), .async_in(async_in),
        .level(lv_bp), .rise(ri_bp), .fall(fa_bp), .tick(tk_bp));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the input value seen at every clock edge since reset,
    // from which sync, tick and the debounce decision are derived.
    logic [W-1:0] hq[$];
    logic [W-1:0] m_lv_db, m_ri_db, m_fa_db, m_lv_bp, m_ri_bp, m_fa_bp;
    logic         m_tk;
    int           m_ticks_disagree[W];

    function automatic logic [W-1:0] a_at(input int k);
        if (k >= 1 && k <= hq.size()) return hq[k-1];
        return '0;
    endfunction

    task automatic model_reset();
        hq.delete();
        m_lv_db = '0; m_ri_db = '0; m_fa_db = '0;
        m_lv_bp = '0; m_ri_bp = '0; m_fa_bp = '0;
        m_tk = 1'b0;
        for (int c = 0; c < W; c++) m_ticks_disagree[c] = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] a);
        int           e;
        logic         tick_seen;
        logic [W-1:0] nl;
        logic [W-1:0] sv;
        hq.push_back(a);
        e = hq.size();
        tick_seen = m_tk;
        // bypass: level is the input seen SB edges earlier
        nl = a_at(e - SB);
        m_ri_bp = ~m_lv_bp & nl;
        m_fa_bp = m_lv_bp & ~nl;
        m_lv_bp = nl;
        // debounce: flip once SS ticks have been seen while sync disagrees throughout
        sv = a_at(e - SD);
        nl = m_lv_db;
        for (int c = 0; c < W; c++) begin
            if (sv[c] == m_lv_db[c]) begin
                m_ticks_disagree[c] = 0;
            end else if (tick_seen) begin
                m_ticks_disagree[c] = m_ticks_disagree[c] + 1;
                if (m_ticks_disagree[c] == SS) begin
                    nl[c] = sv[c];
                    m_ticks_disagree[c] = 0;
                end
            end
        end
        m_ri_db = ~m_lv_db & nl;
        m_fa_db = m_lv_db & ~nl;
        m_lv_db = nl;
        m_tk = ((e % SP) == SP - 1);
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model for the edge just taken, compare both instances.
    task automatic cyc();
        @(negedge clk);
        if (rst_n) model_edge(async_in);
        check("model_db", {lv_db, ri_db, fa_db, tk_db}, {m_lv_db, m_ri_db, m_fa_db, m_tk});
        check("model_bp", {lv_bp, ri_bp, fa_bp, tk_bp}, {m_lv_bp, m_ri_bp, m_fa_bp, 1'b0});
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    // Assert reset between edges, confirm outputs clear without a clock, release after n cycles.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_db", {lv_db, ri_db, fa_db, tk_db}, 13'd0);
        check("rst_async_bp", {lv_bp, ri_bp, fa_bp, tk_bp}, 13'd0);
        cycles(n);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] in;
        int           hold;
        logic [W-1:0] exp_db;
        logic [W-1:0] exp_bp;
    } vec_t;

    vec_t         vt[7];
    int           rem[W];
    int           nfall, nrise;
    logic [W-1:0] seen;
    logic [W-1:0] v;

    initial begin
        vt[0] = '{4'b0101, 20, 4'b0101, 4'b0101};
        vt[1] = '{4'b1111, 20, 4'b1111, 4'b1111};
        vt[2] = '{4'b1010, 20, 4'b1010, 4'b1010};
        vt[3] = '{4'b0110,  4, 4'b1010, 4'b0110};
        vt[4] = '{4'b1010, 20, 4'b1010, 4'b1010};
        vt[5] = '{4'b0000,  8, 4'b1010, 4'b0000};
        vt[6] = '{4'b0000, 20, 4'b0000, 4'b0000};

        #2;
        do_reset(3);

        // Step on channels 0 and 2 right after release: bypass at edge 4, debounce at edge 12.
        async_in = 4'b0101;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (k == 3)  check("bp_before", 13'(lv_bp), 13'd0);
            if (k == 4)  check("bp_flip", 13'({lv_bp, ri_bp}), 13'({4'b0101, 4'b0101}));
            if (k == 5)  check("bp_pulse_end", 13'({lv_bp, ri_bp}), 13'({4'b0101, 4'b0000}));
            if (k == 11) check("db_before", 13'(lv_db), 13'd0);
            if (k == 12) check("db_flip", 13'({lv_db, ri_db, fa_db}), 13'({4'b0101, 4'b0101, 4'b0000}));
            if (k == 13) check("db_pulse_end", 13'({lv_db, ri_db, fa_db}), 13'({4'b0101, 4'b0000, 4'b0000}));
        end

        // Table of steady patterns; short holds must not move the debounced level.
        for (int i = 0; i < 7; i++) begin
            async_in = vt[i].in;
            cycles(vt[i].hold);
            check($sformatf("vec%0d_db", i), 13'(lv_db), 13'(vt[i].exp_db));
            check($sformatf("vec%0d_bp", i), 13'(lv_bp), 13'(vt[i].exp_bp));
        end

        // Glitch train: 6 high / 4 low never lasts SS ticks.
        do_reset(2);
        seen = '0;
        for (int p = 0; p < 10; p++) begin
            async_in = 4'b1111;
            for (int k = 0; k < 6; k++) begin cyc(); seen = seen | lv_db | ri_db | fa_db; end
            async_in = 4'b0000;
            for (int k = 0; k < 4; k++) begin cyc(); seen = seen | lv_db | ri_db | fa_db; end
        end
        check("glitch_quiet", 13'(seen), 13'd0);

        // Reset while two ticks of progress are banked: full latency needed afterwards.
        do_reset(2);
        async_in = 4'b1111;
        cycles(9);
        check("mid_count_low", 13'(lv_db), 13'd0);
        do_reset(3);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 11) check("post_rst_before", 13'(lv_db), 13'd0);
            if (k == 12) check("post_rst_flip", 13'({lv_db, ri_db}), 13'({4'b1111, 4'b1111}));
        end

        // Fall path: bounce in runs of at most 3 cycles, then hold low; exactly one fall.
        do_reset(2);
        async_in = 4'b0001;
        cycles(20);
        check("fall_setup", 13'(lv_db), 13'd1);
        nfall = 0; nrise = 0;
        v = 4'b0001;
        for (int b = 0; b < 16; b++) begin
            v = v ^ 4'b0001;
            async_in = v;
            repeat ($urandom_range(1, 3)) begin
                cyc();
                nfall += int'(fa_db[0]); nrise += int'(ri_db[0]);
            end
        end
        async_in = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            cyc();
            nfall += int'(fa_db[0]); nrise += int'(ri_db[0]);
        end
        check("fall_count", 13'(nfall), 13'd1);
        check("fall_no_rise", 13'(nrise), 13'd0);
        check("fall_level", 13'(lv_db), 13'd0);

        // Random per-channel runs of 1..25 cycles against the model.
        do_reset(2);
        for (int c = 0; c < W; c++) rem[c] = 0;
        for (int k = 0; k < 800; k++) begin
            v = async_in;
            for (int c = 0; c < W; c++) begin
                if (rem[c] == 0) begin
                    v[c] = ~v[c];
                    rem[c] = $urandom_range(1, 25);
                end
                rem[c]--;
            end
            async_in = v;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
